// File: rtl/vending_change_dispenser_if.sv
// Handshake bundle between the vending FSM / coin tubes and the change dispenser.
interface vending_change_dispenser_if #(parameter int AMT_W = 5);
    logic             CHG_REQ;
    logic [AMT_W-1:0] CHG_AMT;
    logic             COIN_ACK;
    logic             EMPTY1;
    logic             EMPTY2;
    logic             EMPTY5;
    logic [2:0]       COIN_CODE;
    logic             COIN_VLD;
    logic             BUSY;
    logic             DONE;
    logic [AMT_W-1:0] SHORT;
    logic [3:0]       COIN_CNT;
    logic             ERR;

    modport master (
        output CHG_REQ, CHG_AMT, COIN_ACK, EMPTY1, EMPTY2, EMPTY5,
        input  COIN_CODE, COIN_VLD, BUSY, DONE, SHORT, COIN_CNT, ERR
    );
    modport slave (
        input  CHG_REQ, CHG_AMT, COIN_ACK, EMPTY1, EMPTY2, EMPTY5,
        output COIN_CODE, COIN_VLD, BUSY, DONE, SHORT, COIN_CNT, ERR
    );
endinterface

// File: rtl/vending_change_dispenser.sv
// Greedy coin-by-coin change ejector with empty-tube skipping, ack timeout and shortfall report.
module vending_change_dispenser #(
    parameter int AMT_W       = 5,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    vending_change_dispenser_if.slave bus
);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FINISH} state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] short_q, short_d;
    logic [2:0]       code_q, code_d;
    logic             vld_q, vld_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            rem_q   <= '0;
            short_q <= '0;
            code_q  <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            tmr_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            short_q <= short_d;
            code_q  <= code_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tmr_q   <= tmr_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        short_d = short_q;
        code_d  = code_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        tmr_d   = tmr_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (bus.CHG_REQ) begin
                    rem_d   = bus.CHG_AMT;
                    short_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                tmr_d = '0;
                if (rem_q >= AMT_W'(5) && !bus.EMPTY5) begin
                    code_d = 3'd5; vld_d = 1'b1; state_d = EJECT;
                end else if (rem_q >= AMT_W'(2) && !bus.EMPTY2) begin
                    code_d = 3'd2; vld_d = 1'b1; state_d = EJECT;
                end else if (rem_q >= AMT_W'(1) && !bus.EMPTY1) begin
                    code_d = 3'd1; vld_d = 1'b1; state_d = EJECT;
                end else begin
                    // Nothing left or no usable tube: whatever remains is the shortfall.
                    short_d = rem_q;
                    state_d = FINISH;
                end
            end
            EJECT: begin
                if (bus.COIN_ACK) begin
                    rem_d   = rem_q - AMT_W'(code_q);
                    cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                    vld_d   = 1'b0;
                    code_d  = '0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : SELECT;
                end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    // Unacked coin is not deducted from the shortfall.
                    err_d   = 1'b1;
                    vld_d   = 1'b0;
                    code_d  = '0;
                    short_d = rem_q;
                    state_d = FINISH;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            GAP: begin
                if (int'(gap_q) + 1 >= GAP_CYCLES) state_d = SELECT;
                else                               gap_d   = gap_q + GAP_W'(1);
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.COIN_CODE = code_q;
    assign bus.COIN_VLD  = vld_q;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.DONE      = (state_q == FINISH);
    assign bus.SHORT     = short_q;
    assign bus.COIN_CNT  = cnt_q;
    assign bus.ERR       = err_q;
endmodule

// File: tb/tb_vending_change_dispenser.sv
// Directed bench for the change dispenser: coin and end-of-transaction scoreboards, ack responder.
module tb_vending_change_dispenser;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    vending_change_dispenser_if #(.AMT_W(5)) bus();
    vending_change_dispenser #(.AMT_W(5), .GAP_CYCLES(2), .ACK_TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    typedef struct { int short_v; int cnt; int err; } res_t;
    int   exp_codes[$];
    res_t exp_res[$];
    int   n_vec = 0, n_err = 0, n_done = 0;
    int   last_len = 0, last_gap = 0;
    bit   ack_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ack responder: acknowledges one cycle after seeing COIN_VLD.
    initial begin
        bus.COIN_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.COIN_VLD && ack_en) begin
                @(negedge CLK);
                bus.COIN_ACK = 1'b1;
                @(negedge CLK);
                bus.COIN_ACK = 1'b0;
            end
        end
    end

    // Output monitor: pops scoreboards on coin rise and DONE.
    initial begin
        logic       pv = 1'b0;
        logic [2:0] pc = '0;
        int vlen = 0, glen = 0;
        res_t r;
        forever begin
            @(posedge CLK); #1;
            if (bus.COIN_VLD && !pv) begin
                last_gap = glen;
                if (exp_codes.size() == 0) chk("unexpected_coin", 32'(bus.COIN_CODE), 0);
                else chk("coin_code", 32'(bus.COIN_CODE), 32'(exp_codes.pop_front()));
            end
            if (bus.COIN_VLD && pv) chk("code_stable", 32'(bus.COIN_CODE), 32'(pc));
            if (!bus.COIN_VLD) chk("code_idle_zero", 32'(bus.COIN_CODE), 0);
            if (!bus.COIN_VLD && pv) begin last_len = vlen; glen = 0; end
            vlen = bus.COIN_VLD ? vlen + 1 : 0;
            if (!bus.COIN_VLD) glen++;
            if (bus.DONE) begin
                n_done++;
                if (exp_res.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    r = exp_res.pop_front();
                    chk("short", 32'(bus.SHORT), 32'(r.short_v));
                    chk("coin_cnt", 32'(bus.COIN_CNT), 32'(r.cnt));
                    chk("err", 32'(bus.ERR), 32'(r.err));
                end
            end
            pv = bus.COIN_VLD;
            pc = bus.COIN_CODE;
        end
    end

    task automatic request(input int amt);
        @(negedge CLK);
        bus.CHG_REQ = 1'b1;
        bus.CHG_AMT = 5'(amt);
        @(posedge CLK); #1;
        chk("busy_after_req", 32'(bus.BUSY), 1);
        @(negedge CLK);
        bus.CHG_REQ = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int start = n_done;
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge CLK); #2;
            if (n_done != start) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        @(posedge CLK); #2;
        chk({tag, "_idle"}, 32'(bus.BUSY), 0);
    endtask

    task automatic wait_vld(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge CLK); #2;
            if (bus.COIN_VLD) seen = 1'b1;
        end
        chk({tag, "_vld_seen"}, 32'(seen), 1);
    endtask

    initial begin
        int done0;
        bus.CHG_REQ = 1'b0; bus.CHG_AMT = '0;
        bus.EMPTY1 = 1'b0; bus.EMPTY2 = 1'b0; bus.EMPTY5 = 1'b0;
        #12;
        chk("rst_code", 32'(bus.COIN_CODE), 0);
        chk("rst_vld", 32'(bus.COIN_VLD), 0);
        chk("rst_busy", 32'(bus.BUSY), 0);
        chk("rst_done", 32'(bus.DONE), 0);
        chk("rst_short", 32'(bus.SHORT), 0);
        chk("rst_cnt", 32'(bus.COIN_CNT), 0);
        chk("rst_err", 32'(bus.ERR), 0);
        @(negedge CLK); RST = 1'b1;

        // 8 -> 5,2,1
        exp_codes.push_back(5); exp_codes.push_back(2); exp_codes.push_back(1);
        exp_res.push_back('{0, 3, 0});
        request(8); wait_done("amt8");

        // 9 with no fives -> 2,2,2,2,1
        bus.EMPTY5 = 1'b1;
        for (int i = 0; i < 4; i++) exp_codes.push_back(2);
        exp_codes.push_back(1);
        exp_res.push_back('{0, 5, 0});
        request(9); wait_done("amt9");

        // 3 with no ones -> 2, short 1
        bus.EMPTY5 = 1'b0; bus.EMPTY1 = 1'b1;
        exp_codes.push_back(2);
        exp_res.push_back('{1, 1, 0});
        request(3); wait_done("amt3");
        bus.EMPTY1 = 1'b0;

        // 0 -> DONE two cycles after the request cycle, no coin
        exp_res.push_back('{0, 0, 0});
        @(negedge CLK); bus.CHG_REQ = 1'b1; bus.CHG_AMT = 5'd0;
        @(posedge CLK); #1;
        chk("amt0_select_no_done", 32'(bus.DONE), 0);
        @(negedge CLK); bus.CHG_REQ = 1'b0;
        @(posedge CLK); #1;
        chk("amt0_done", 32'(bus.DONE), 1);
        @(posedge CLK); #2;
        chk("amt0_idle", 32'(bus.BUSY), 0);

        // 5 never acked -> timeout
        ack_en = 1'b0;
        exp_codes.push_back(5);
        exp_res.push_back('{5, 0, 1});
        request(5); wait_done("timeout");
        chk("timeout_vld_len", 32'(last_len), 16);
        ack_en = 1'b1;

        // 2 with a second request while busy -> only code 2
        exp_codes.push_back(2);
        exp_res.push_back('{0, 1, 0});
        request(2);
        bus.CHG_REQ = 1'b1; bus.CHG_AMT = 5'd7;
        @(negedge CLK); bus.CHG_REQ = 1'b0;
        wait_done("ignored_req");

        // 3 -> 2,1; fall-to-rise spacing across GAP,GAP,SELECT
        exp_codes.push_back(2); exp_codes.push_back(1);
        exp_res.push_back('{0, 2, 0});
        request(3); wait_done("gap");
        chk("gap_spacing", 32'(last_gap), 3);

        // Reset during EJECT
        ack_en = 1'b0;
        exp_codes.push_back(5);
        done0 = n_done;
        request(5); wait_vld("midrst");
        @(negedge CLK); RST = 1'b0; #1;
        chk("midrst_code", 32'(bus.COIN_CODE), 0);
        chk("midrst_vld", 32'(bus.COIN_VLD), 0);
        chk("midrst_busy", 32'(bus.BUSY), 0);
        chk("midrst_done", 32'(bus.DONE), 0);
        chk("midrst_short", 32'(bus.SHORT), 0);
        chk("midrst_cnt", 32'(bus.COIN_CNT), 0);
        chk("midrst_err", 32'(bus.ERR), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        chk("midrst_no_done", 32'(n_done), 32'(done0));
        ack_en = 1'b1;
        exp_codes.push_back(1);
        exp_res.push_back('{0, 1, 0});
        request(1); wait_done("post_rst");

        repeat (4) @(posedge CLK);
        #2;
        chk("coin_queue_empty", 32'(exp_codes.size()), 0);
        chk("res_queue_empty", 32'(exp_res.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vending_change_dispenser.md
Name: vending_change_dispenser

Overview:
Change-return back end of the vending machine. Takes a change amount from the vending FSM and ejects it one coin at a time to the coin tubes over a valid/ack handshake. Coins are driven on the same 3-bit coin encoding the vending FSM accepts on IN (1, 2, 5). It uses greedy denomination selection, skips empty tubes, applies an ack timeout, and reports any shortfall back to the vending FSM.

Parameters:
AMT_W, 5, width of change amount and shortfall (max 31 units)
GAP_CYCLES, 2, idle cycles forced between consecutive ejects (0 allowed)
ACK_TIMEOUT, 16, cycles to wait for COIN_ACK before aborting (>=1)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
CHG_REQ  input  1  change request; sampled only in IDLE
CHG_AMT  input  AMT_W  change amount, captured with CHG_REQ
COIN_ACK  input  1  tube mechanism accepted current coin
EMPTY1  input  1  tube for code 1 empty
EMPTY2  input  1  tube for code 2 empty
EMPTY5  input  1  tube for code 5 empty
COIN_CODE  output  3  coin being ejected: 3'd1, 3'd2 or 3'd5; 3'd0 when not valid
COIN_VLD  output  1  eject request, held until ack or timeout
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle pulse at end of transaction
SHORT  output  AMT_W  undispensed remainder; valid from DONE until next accepted request
COIN_CNT  output  4  coins ejected in the current or last transaction, saturating at 15
ERR  output  1  set on ack timeout; cleared on next accepted request

Behaviour:
- Reset (async, RST=0): state IDLE. All outputs 0: COIN_CODE, COIN_VLD, BUSY, DONE, SHORT, COIN_CNT, ERR. Internal remainder is 0.
- States: IDLE, SELECT, EJECT, GAP, FINISH.
- IDLE:
  - If CHG_REQ=1 at an edge: capture CHG_AMT into rem. Clear SHORT, COIN_CNT and ERR. Go to SELECT.
  - BUSY goes high the cycle after the request edge.
- SELECT (1 cycle), greedy choice on rem and the empty flags, evaluated in this order:
  - rem>=5 and !EMPTY5 -> code 5
  - else rem>=2 and !EMPTY2 -> code 2
  - else rem>=1 and !EMPTY1 -> code 1
  - else -> FINISH with no coin.
  - When a coin is chosen: register COIN_CODE and set COIN_VLD=1 on entering EJECT.
  - rem=0 -> FINISH (SHORT=0).
  - rem>0 with no usable tube -> FINISH with SHORT=rem.
- EJECT:
  - COIN_VLD and COIN_CODE are held stable.
  - On COIN_ACK=1 at an edge: rem -= code; COIN_CNT += 1 (saturating); COIN_VLD<=0 and COIN_CODE<=0. Next state is GAP if GAP_CYCLES>0, else SELECT.
  - Ack timer counts edges in EJECT without ack. When it reaches ACK_TIMEOUT: ERR<=1, COIN_VLD<=0, SHORT<=rem (current coin not deducted), go to FINISH.
  - COIN_ACK outside EJECT is ignored.
- GAP: counts exactly GAP_CYCLES cycles, then goes to SELECT.
- Empty flags are sampled only in SELECT. A flag changing during EJECT does not cancel the current coin.
- FINISH (1 cycle):
  - DONE=1; SHORT<=rem unless already loaded by timeout.
  - Next state IDLE.
  - BUSY drops in IDLE.
- CHG_REQ while BUSY is ignored and not queued. CHG_REQ held high through FINISH starts a new transaction on the first IDLE edge.
- Minimum latency per coin (GAP_CYCLES=0, immediate ack): 2 cycles (SELECT, EJECT).
- Reset mid-transaction: immediate abort, all outputs to reset values, no DONE pulse, rem discarded.
- Arithmetic: rem is AMT_W bits and never underflows, since code<=rem is guaranteed at selection.

Test Plan:
- Amount 8, no tubes empty, ack 1 cycle after each COIN_VLD -> COIN_CODE sequence 5,2,1; DONE once; SHORT=0; COIN_CNT=3; ERR=0.
- Amount 9, EMPTY5=1 -> codes 2,2,2,2,1; COIN_CNT=5; SHORT=0.
- Amount 3, EMPTY1=1 -> code 2 only, then DONE with SHORT=1 and COIN_CNT=1. Amount 0 -> no COIN_VLD; DONE 2 cycles after request; SHORT=0.
- Amount 5, COIN_ACK never asserted -> COIN_VLD high exactly ACK_TIMEOUT (16) cycles, then dropped; ERR=1; SHORT=5; COIN_CNT=0; DONE pulses.
- Second CHG_REQ with amount 7 during first transaction (amount 2) -> ignored; only code 2 ejected. Verify GAP_CYCLES=2 spacing between COIN_VLD fall and the next rise: 3 cycles (GAP, GAP, SELECT).
- RST low while COIN_VLD=1 in EJECT -> all outputs 0 immediately; no DONE. After release, a new request for amount 1 dispenses code 1 normally.
